// File: rtl/fetch_npc_if.sv
// EX-stage branch resolution bundle into the next-PC generator.
// master = EX stage, slave = fetch_npc.
interface fetch_npc_if;
  logic        ex_valid;
  logic        ex_is_cond;
  logic [31:0] ex_pc;
  logic        ex_actual_taken;
  logic [31:0] ex_actual_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;

  modport master (
    output ex_valid, ex_is_cond, ex_pc,
    output ex_actual_taken, ex_actual_target,
    output ex_pred_taken, ex_pred_target
  );

  modport slave (
    input ex_valid, ex_is_cond, ex_pc,
    input ex_actual_taken, ex_actual_target,
    input ex_pred_taken, ex_pred_target
  );
endinterface

// File: rtl/fetch_npc.sv
// Next-PC generator: fetch PC register, direct-mapped BTB,
// mispredict detection/redirect and branch statistics.
module fetch_npc #(
  parameter int          BTB_ENTRIES = 64,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  output logic [31:0] pc_if,
  input  logic        gs_pred_taken_if,
  output logic        pred_taken_if,
  output logic [31:0] pred_target_if,
  fetch_npc_if.slave  ex,
  output logic        gs_update_en,
  output logic        gs_actual_taken,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int IDX = $clog2(BTB_ENTRIES);
  localparam int TW  = 30 - IDX;

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [BTB_ENTRIES-1:0] btb_unc;
  logic [TW-1:0]          btb_tag [BTB_ENTRIES];
  logic [31:0]            btb_tgt [BTB_ENTRIES];

  logic [IDX-1:0] if_idx;
  logic [IDX-1:0] ex_idx;
  logic [TW-1:0]  if_tag;
  logic [TW-1:0]  ex_tag;
  logic           hit;
  logic           btb_wr;
  logic [31:0]    pc_seq;
  logic [31:0]    pc_nxt;

  assign if_idx = pc_if[IDX+1:2];
  assign if_tag = pc_if[31:IDX+2];
  assign ex_idx = ex.ex_pc[IDX+1:2];
  assign ex_tag = ex.ex_pc[31:IDX+2];

  assign hit = btb_valid[if_idx]
             & (btb_tag[if_idx] == if_tag);

  assign pred_taken_if = hit
                       & (btb_unc[if_idx] | gs_pred_taken_if);

  assign pc_seq = pc_if + 32'd4;

  assign pred_target_if = pred_taken_if
                        ? btb_tgt[if_idx] : pc_seq;

  assign redirect = ex.ex_valid
    & ((ex.ex_actual_taken != ex.ex_pred_taken)
     | (ex.ex_actual_taken
      & (ex.ex_actual_target != ex.ex_pred_target)));

  assign redirect_pc = ex.ex_actual_taken
                     ? ex.ex_actual_target
                     : ex.ex_pc + 32'd4;

  assign gs_update_en    = ex.ex_valid & ex.ex_is_cond;
  assign gs_actual_taken = ex.ex_actual_taken;

  assign btb_wr = ex.ex_valid & ex.ex_actual_taken;

  // Redirect beats stall; stall beats prediction.
  always_comb begin
    pc_nxt = pred_target_if;
    if (redirect) begin
      pc_nxt = redirect_pc;
    end else if (stall_if) begin
      pc_nxt = pc_if;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_if <= RESET_PC;
    end else begin
      pc_if <= pc_nxt;
    end
  end

  // BTB valid bits; reset invalidates every entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btb_valid <= '0;
    end else if (btb_wr) begin
      btb_valid[ex_idx] <= 1'b1;
    end
  end

  // BTB payload; only meaningful behind a valid bit.
  always_ff @(posedge clk) begin
    if (btb_wr) begin
      btb_tag[ex_idx] <= ex_tag;
      btb_tgt[ex_idx] <= ex.ex_actual_target;
      btb_unc[ex_idx] <= ~ex.ex_is_cond;
    end
  end

  // Saturating resolved-branch and mispredict counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (ex.ex_valid && branch_cnt != '1) begin
        branch_cnt <= branch_cnt + 32'd1;
      end
      if (redirect && mispred_cnt != '1) begin
        mispred_cnt <= mispred_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_npc.sv
// Bench for fetch_npc: directed scenarios plus random
// traffic, checked every cycle against a behavioural model.
module tb_fetch_npc;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int          N   = 64;
  localparam logic [31:0] MAX = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_if = 1'b0;
  logic        gs = 1'b0;
  logic [31:0] pc_if;
  logic        pred_taken_if;
  logic [31:0] pred_target_if;
  logic        gs_update_en;
  logic        gs_actual_taken;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  fetch_npc_if exb ();

  fetch_npc #(
    .BTB_ENTRIES(N),
    .RESET_PC(RPC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall_if(stall_if),
    .pc_if(pc_if),
    .gs_pred_taken_if(gs),
    .pred_taken_if(pred_taken_if),
    .pred_target_if(pred_target_if),
    .ex(exb),
    .gs_update_en(gs_update_en),
    .gs_actual_taken(gs_actual_taken),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt),
    .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: each slot remembers the full PC that trained it.
  logic        m_v   [N];
  logic [31:0] m_src [N];
  logic [31:0] m_tgt [N];
  logic        m_unc [N];
  logic [31:0] m_pc;
  logic [31:0] m_bc;
  logic [31:0] m_mc;

  function automatic int slot(input logic [31:0] a);
    return int'((a >> 2) % N);
  endfunction

  function automatic logic m_pred(input logic [31:0] a);
    int i;
    i = slot(a);
    return m_v[i] && ((m_src[i] >> 2) == (a >> 2))
        && (m_unc[i] || gs);
  endfunction

  function automatic logic [31:0] m_ptgt(input logic [31:0] a);
    if (m_pred(a)) return m_tgt[slot(a)];
    return a + 32'd4;
  endfunction

  function automatic logic m_mis();
    if (!exb.ex_valid) return 1'b0;
    if (exb.ex_actual_taken != exb.ex_pred_taken) return 1'b1;
    return exb.ex_actual_taken
        && (exb.ex_actual_target != exb.ex_pred_target);
  endfunction

  function automatic logic [31:0] m_rpc();
    if (exb.ex_actual_taken) return exb.ex_actual_target;
    return exb.ex_pc + 32'd4;
  endfunction

  always @(posedge clk or negedge rst) begin
    logic [31:0] nxt;
    logic        mis;
    int          i;
    if (!rst) begin
      m_pc = RPC;
      m_bc = 0;
      m_mc = 0;
      for (int k = 0; k < N; k++) m_v[k] = 1'b0;
    end else begin
      mis = m_mis();
      if (mis) nxt = m_rpc();
      else if (stall_if) nxt = m_pc;
      else nxt = m_ptgt(m_pc);
      if (exb.ex_valid && exb.ex_actual_taken) begin
        i = slot(exb.ex_pc);
        m_v[i]   = 1'b1;
        m_src[i] = exb.ex_pc;
        m_tgt[i] = exb.ex_actual_target;
        m_unc[i] = !exb.ex_is_cond;
      end
      if (exb.ex_valid && m_bc != MAX) m_bc = m_bc + 1;
      if (mis && m_mc != MAX) m_mc = m_mc + 1;
      m_pc = nxt;
    end
  end

  always @(negedge clk) begin
    chk("pc_if", pc_if, m_pc);
    chk("pred_taken_if", 32'(pred_taken_if), 32'(m_pred(m_pc)));
    chk("pred_target_if", pred_target_if, m_ptgt(m_pc));
    chk("redirect", 32'(redirect), 32'(m_mis()));
    if (m_mis()) chk("redirect_pc", redirect_pc, m_rpc());
    chk("gs_update_en", 32'(gs_update_en),
        32'(exb.ex_valid && exb.ex_is_cond));
    chk("gs_actual_taken", 32'(gs_actual_taken),
        32'(exb.ex_actual_taken));
    chk("branch_cnt", branch_cnt, m_bc);
    chk("mispred_cnt", mispred_cnt, m_mc);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_set(input logic v, input logic c,
                        input logic [31:0] p,
                        input logic a, input logic [31:0] t,
                        input logic pt, input logic [31:0] ptg);
    exb.ex_valid         = v;
    exb.ex_is_cond       = c;
    exb.ex_pc            = p;
    exb.ex_actual_taken  = a;
    exb.ex_actual_target = t;
    exb.ex_pred_taken    = pt;
    exb.ex_pred_target   = ptg;
  endtask

  task automatic ex_idle();
    exb.ex_valid = 1'b0;
  endtask

  // Steer fetch to a via a not-taken mispredict at a-4.
  task automatic jump_to(input logic [31:0] a);
    ex_set(1'b1, 1'b1, a - 32'd4, 1'b0, 32'h0, 1'b1, 32'h0);
    step();
    ex_idle();
  endtask

  function automatic logic [31:0] rnd_pc();
    logic [31:0] a;
    a = (32'($urandom_range(0, 3)) << 8)
      | (32'($urandom_range(0, 7)) << 2);
    return a;
  endfunction

  initial begin
    ex_set(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("lit_rst_pc", pc_if, 32'h100);
    chk("lit_rst_ptgt", pred_target_if, 32'h104);
    chk("lit_rst_pt", 32'(pred_taken_if), 32'h0);
    rst = 1'b1;
    step();
    chk("lit_seq_104", pc_if, 32'h104);
    step();
    chk("lit_seq_108", pc_if, 32'h108);
    stall_if = 1'b1;
    step();
    chk("lit_stall1", pc_if, 32'h108);
    step();
    chk("lit_stall2", pc_if, 32'h108);
    stall_if = 1'b0;
    step();
    chk("lit_seq_10c", pc_if, 32'h10C);

    ex_set(1'b1, 1'b1, 32'h104, 1'b1, 32'h200, 1'b0, 32'h0);
    #1;
    chk("lit_cold_redirect", 32'(redirect), 32'h1);
    chk("lit_cold_rpc", redirect_pc, 32'h200);
    chk("lit_cold_gsupd", 32'(gs_update_en), 32'h1);
    step();
    ex_idle();
    chk("lit_cold_pc", pc_if, 32'h200);
    chk("lit_cold_mcnt", mispred_cnt, 32'h1);
    jump_to(32'h104);
    gs = 1'b1;
    #1;
    chk("lit_hit_pt", 32'(pred_taken_if), 32'h1);
    chk("lit_hit_tgt", pred_target_if, 32'h200);
    gs = 1'b0;

    ex_set(1'b1, 1'b0, 32'h300, 1'b1, 32'h40, 1'b0, 32'h0);
    step();
    ex_idle();
    chk("lit_jal_pc", pc_if, 32'h40);
    jump_to(32'h300);
    #1;
    chk("lit_jal_pt", 32'(pred_taken_if), 32'h1);
    chk("lit_jal_tgt", pred_target_if, 32'h40);
    ex_set(1'b1, 1'b0, 32'h300, 1'b1, 32'h40, 1'b1, 32'h40);
    #1;
    chk("lit_jal_gsupd", 32'(gs_update_en), 32'h0);
    chk("lit_jal_noredir", 32'(redirect), 32'h0);
    step();
    ex_idle();
    chk("lit_jal_follow", pc_if, 32'h40);

    ex_set(1'b1, 1'b1, 32'h104, 1'b1, 32'h280, 1'b1, 32'h200);
    #1;
    chk("lit_wt_redirect", 32'(redirect), 32'h1);
    chk("lit_wt_rpc", redirect_pc, 32'h280);
    step();
    ex_idle();
    chk("lit_wt_pc", pc_if, 32'h280);
    jump_to(32'h104);
    gs = 1'b1;
    #1;
    chk("lit_wt_newtgt", pred_target_if, 32'h280);
    ex_set(1'b1, 1'b1, 32'h104, 1'b0, 32'h0, 1'b1, 32'h280);
    #1;
    chk("lit_nt_rpc", redirect_pc, 32'h108);
    step();
    ex_idle();
    chk("lit_nt_pc", pc_if, 32'h108);
    jump_to(32'h104);
    #1;
    chk("lit_nt_keep", 32'(pred_taken_if), 32'h1);

    stall_if = 1'b1;
    ex_set(1'b1, 1'b1, 32'h104, 1'b1, 32'h1C0, 1'b0, 32'h0);
    step();
    ex_idle();
    chk("lit_prio_pc", pc_if, 32'h1C0);
    stall_if = 1'b0;

    ex_set(1'b1, 1'b1, 32'h204, 1'b1, 32'h500, 1'b0, 32'h0);
    step();
    ex_idle();
    jump_to(32'h104);
    #1;
    chk("lit_alias_pt", 32'(pred_taken_if), 32'h0);
    chk("lit_alias_tgt", pred_target_if, 32'h108);

    jump_to(32'h204);
    ex_set(1'b1, 1'b1, 32'h204, 1'b1, 32'h600, 1'b1, 32'h600);
    #1;
    chk("lit_rw_old", pred_target_if, 32'h500);
    step();
    ex_idle();
    chk("lit_rw_pc", pc_if, 32'h500);
    jump_to(32'h204);
    #1;
    chk("lit_rw_new", pred_target_if, 32'h600);
    gs = 1'b0;

    ex_set(1'b1, 1'b0, 32'h10, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    step();
    ex_idle();
    chk("lit_wrap_top", pc_if, 32'hFFFF_FFFC);
    step();
    chk("lit_wrap_zero", pc_if, 32'h0);

    force dut.mispred_cnt = 32'hFFFF_FFFD;
    m_mc = 32'hFFFF_FFFD;
    #1;
    release dut.mispred_cnt;
    repeat (3) begin
      ex_set(1'b1, 1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 32'h0);
      step();
    end
    ex_idle();
    chk("lit_sat", mispred_cnt, MAX);

    ex_set(1'b1, 1'b1, 32'h104, 1'b1, 32'h700, 1'b0, 32'h0);
    #1;
    rst = 1'b0;
    #1;
    chk("lit_midrst_pc", pc_if, 32'h100);
    step();
    chk("lit_midrst_hold", pc_if, 32'h100);
    chk("lit_midrst_cnt", mispred_cnt, 32'h0);
    ex_idle();
    rst = 1'b1;
    step();
    jump_to(32'h300);
    gs = 1'b1;
    #1;
    chk("lit_midrst_btb", 32'(pred_taken_if), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      logic        c;
      logic [31:0] t;
      rst      = ($urandom_range(0, 199) != 0);
      stall_if = ($urandom_range(0, 4) == 0);
      gs       = 1'($urandom_range(0, 1));
      c        = ($urandom_range(0, 3) != 0);
      t        = rnd_pc();
      ex_set(($urandom_range(0, 9) < 4), c, rnd_pc(),
             c ? 1'($urandom_range(0, 1)) : 1'b1, t,
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 1) == 1) ? t : rnd_pc());
      step();
    end
    rst = 1'b1;
    ex_idle();
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_npc.md
# fetch_npc

Next-PC generator for the IF stage. It holds the fetch PC register and a direct-mapped branch target buffer (BTB). It combines BTB hits with the gshare direction predictor's `pred_taken_if` to choose the next fetch address. From EX it takes resolved branch outcomes, detects mispredicts, redirects fetch, trains the BTB, and forwards training to gshare.

## Interface
- `BTB_ENTRIES`, 64: number of BTB entries; must be a power of 2, at least 4. `IDX = log2(BTB_ENTRIES)`.
- `RESET_PC`, 32'h0000_0000: fetch address after reset.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `stall_if`  in  1  hold the fetch PC (downstream back-pressure).
- `pc_if`  out  32  current fetch PC; this is the value fed to gshare `pc_if`.
- `gs_pred_taken_if`  in  1  gshare direction for `pc_if`.
- `pred_taken_if`  out  1  final predicted-taken for `pc_if`.
- `pred_target_if`  out  32  predicted target: BTB target if `pred_taken_if`, else `pc_if+4`.
- `ex_valid`  in  1  a branch-like instruction resolves in EX this cycle.
- `ex_is_cond`  in  1  conditional branch (0 means jal/jalr).
- `ex_pc`  in  32  PC of the resolving instruction.
- `ex_actual_taken`  in  1  real outcome; must be 1 when `ex_is_cond`=0.
- `ex_actual_target`  in  32  real taken target.
- `ex_pred_taken`  in  1  `pred_taken_if` carried down the pipe.
- `ex_pred_target`  in  32  `pred_target_if` carried down the pipe.
- `gs_update_en`  out  1  `ex_valid & ex_is_cond`.
- `gs_actual_taken`  out  1  `ex_actual_taken` passed through.
- `redirect`  out  1  mispredict; flush IF/ID and ID/EX.
- `redirect_pc`  out  32  correct next PC.
- `branch_cnt`  out  32  resolved branch-like count.
- `mispred_cnt`  out  32  mispredict count.

## Operation
- BTB entry fields: `valid`, `tag` = pc[31:2+IDX], `target`[31:0], `uncond`.
- BTB index = pc[IDX+1:2].
- Lookup on `pc_if`, combinational:
  - `hit` = valid & tag match.
  - `pred_taken_if` = `hit & (uncond | gs_pred_taken_if)`.
- Mispredict (combinational, qualified by `ex_valid`):
  - `ex_actual_taken != ex_pred_taken`, or
  - `ex_actual_taken & (ex_actual_target != ex_pred_target)`.
- `redirect_pc` = `ex_actual_taken ? ex_actual_target : ex_pc+4`. It is valid only while `redirect`=1 and is don't-care otherwise.
- Next-PC priority, evaluated every cycle:
  1. `redirect`: load `redirect_pc`.
  2. `stall_if`: hold `pc_if`.
  3. `pred_taken_if`: load `pred_target_if`.
  4. Otherwise: load `pc_if+4`.
- A redirect overrides `stall_if`.
- BTB write happens on `ex_valid & ex_actual_taken`, at index/tag from `ex_pc`. It sets `valid`=1, `target`=`ex_actual_target`, `uncond`=`~ex_is_cond`, replacing any previous occupant.
- A resolved not-taken branch never modifies the BTB.
- `gs_update_en` / `gs_actual_taken` are combinational pass-throughs. The gshare PHT index is carried by the pipeline, not by this block.
- Counters, both saturating at 32'hFFFF_FFFF:
  - `branch_cnt` += 1 on `ex_valid`.
  - `mispred_cnt` += 1 on `redirect`.
- All addresses are 32-bit. `+4` wraps modulo 2^32: 32'hFFFF_FFFC+4 = 0.

## Timing
- Reset (asynchronous, `rst`=0):
  - `pc_if`=`RESET_PC`.
  - All BTB `valid`=0.
  - Both counters 0.
  - Hence `pred_taken_if`=0 and `pred_target_if`=`RESET_PC+4` while in reset.
  - `redirect`, `gs_update_en`, `gs_actual_taken` follow their inputs combinationally, including during reset.
- Reset asserted mid-operation discards any in-flight redirect or BTB write immediately.
- After `rst` deasserts, the first edge updates `pc_if` per the next-PC priority.
- Prediction: same cycle as `pc_if` (combinational from the register and BTB).
- Next fetch address is visible on `pc_if` one edge later.
- Redirect latency: `redirect` in cycle N gives `pc_if`=`redirect_pc` in cycle N+1. There is no bubble inside this block.
- BTB write in cycle N is visible to lookups from cycle N+1. A lookup in cycle N at the index being written sees the pre-write contents.
- Counters update on the same edge as the event.

## Test plan
- **Reset and sequential fetch.** Set `RESET_PC`=32'h100 and release reset with no EX activity. Required: `pc_if` = 100, 104, 108… with `pred_taken_if`=0. Asserting `stall_if` for 2 cycles holds 108 for those cycles.
- **Cold taken branch.**
  - Stimulus: EX presents `ex_pc`=32'h104, cond, taken, target 32'h200, `ex_pred_taken`=0.
  - Required: `redirect`=1, `redirect_pc`=200, and `pc_if`=200 on the next cycle.
  - Required: `mispred_cnt`=1, `gs_update_en`=1.
  - Required: with `gs_pred_taken_if`=1, a later fetch of 104 predicts taken with target 200.
- **Unconditional jump.** Train jal at 32'h300 with target 32'h40. Required: a later fetch of 300 with `gs_pred_taken_if`=0 still predicts taken to 40, and `gs_update_en`=0 on its resolution.
- **Wrong target and not-taken correction.**
  - Stimulus: resolve taken with `ex_actual_target` 32'h280 while the carried prediction was taken with target 200.
  - Required: redirect to 280 and the BTB entry is updated.
  - Stimulus: resolve not-taken while the carried prediction was taken.
  - Required: `redirect_pc`=`ex_pc+4` and the BTB entry remains valid.
- **Priority and aliasing.**
  - Stimulus: `redirect` coincides with `stall_if`. Required: PC loads `redirect_pc`.
  - Stimulus: with `BTB_ENTRIES`=64, train 32'h104 and then 32'h204 (same index, different tag). Required: fetch of 104 misses.
  - Stimulus: lookup at the index being written in the same cycle. Required: old entry returned.
- **Wrap, counter saturation, reset mid-operation.**
  - Required: `pc_if` 32'hFFFF_FFFC is followed by 0.
  - Stimulus: force `mispred_cnt` near saturation and apply further mispredicts. Required: the counter sticks at all-ones.
  - Stimulus: assert `rst` during a redirect cycle. Required: `pc_if`=`RESET_PC` and BTB invalid afterwards.
